// File: rtl/ip_hdr_ctrl_pkg.sv
// Shared types and defaults for the IP header generator sequencer.
package ip_ctrl_pkg;

    localparam int STROBE_CYC_DEF  = 2;
    localparam int GAP_CYC_DEF     = 2;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_ISSUE    = 4'b0010,
        ST_WAIT_RDY = 4'b0100,
        ST_GAP      = 4'b1000
    } state_e;

    typedef enum logic {
        GRANT_SEND = 1'b0,
        GRANT_CFG  = 1'b1
    } grant_e;

    localparam logic CFG_LOCAL = 1'b0;
    localparam logic CFG_DEST  = 1'b1;

endpackage

// File: rtl/ip_hdr_ctrl_if.sv
// Request/ack handshakes from the command parser and frame packer, plus the generator-side strobes and data.
interface ip_hdr_ctrl_if;

    logic        i_cfg_req;
    logic        i_cfg_dst;
    logic [31:0] i_cfg_ip;
    logic        o_cfg_ack;
    logic        o_cfg_done;
    logic        i_send_req;
    logic [15:0] i_send_len;
    logic        o_send_ack;
    logic        o_send_done;
    logic        o_ip_trig;
    logic        o_ip_set_local;
    logic        o_ip_set_dest;
    logic [15:0] o_ip_data_length;
    logic [7:0]  o_ip0;
    logic [7:0]  o_ip1;
    logic [7:0]  o_ip2;
    logic [7:0]  o_ip3;
    logic        i_ip_ready;
    logic        o_busy;
    logic        o_err;

    modport slave (
        input  i_cfg_req, i_cfg_dst, i_cfg_ip, i_send_req, i_send_len, i_ip_ready,
        output o_cfg_ack, o_cfg_done, o_send_ack, o_send_done,
        output o_ip_trig, o_ip_set_local, o_ip_set_dest,
        output o_ip_data_length, o_ip0, o_ip1, o_ip2, o_ip3, o_busy, o_err
    );

    modport master (
        output i_cfg_req, i_cfg_dst, i_cfg_ip, i_send_req, i_send_len, i_ip_ready,
        input  o_cfg_ack, o_cfg_done, o_send_ack, o_send_done,
        input  o_ip_trig, o_ip_set_local, o_ip_set_dest,
        input  o_ip_data_length, o_ip0, o_ip1, o_ip2, o_ip3, o_busy, o_err
    );

endinterface

// File: rtl/ip_hdr_ctrl_timer.sv
// Clear/enable up-counter with terminal-count flag; shared by strobe, gap and timeout counts.
module ip_ctrl_timer #(
    parameter int W = 7
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_tc_val,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
    assign o_tc  = (cnt_q == i_tc_val);

endmodule

// File: rtl/ip_hdr_ctrl.sv
// Arbitrates config/send requests and sequences the IP header generator strobes, ready and timeout.
// state       | meaning
// IDLE        | arbitrating, all strobes low
// ISSUE       | strobe high for STROBE_CYC cycles
// WAIT_RDY    | strobes low, waiting for generator ready or timeout
// GAP         | GAP_CYC idle cycles before the next grant
module ip_hdr_ctrl
    import ip_ctrl_pkg::*;
#(
    parameter int STROBE_CYC  = STROBE_CYC_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ip_hdr_ctrl_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] STB_TC = TW'(STROBE_CYC - 1);
    localparam logic [TW-1:0] GAP_TC = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TO_TC  = TW'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    grant_e      last_grant_q, last_grant_d;
    logic        cfg_ack_q, cfg_ack_d;
    logic        send_ack_q, send_ack_d;
    logic        cfg_done_q, cfg_done_d;
    logic        send_done_q, send_done_d;
    logic        err_q, err_d;
    logic        trig_q, trig_d;
    logic        set_local_q, set_local_d;
    logic        set_dest_q, set_dest_d;
    logic [15:0] len_q, len_d;
    logic [31:0] ip_q, ip_d;

    logic          grant_cfg;
    logic          in_op;
    logic          timeout_hit;
    logic          tmr_clr;
    logic          tmr_en;
    logic          tmr_tc;
    logic [TW-1:0] tmr_cnt;
    logic [TW-1:0] tmr_tc_val;

    assign in_op       = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RDY);
    assign timeout_hit = in_op && (tmr_cnt == TO_TC);
    assign tmr_tc_val  = (state_q == ST_GAP) ? GAP_TC : STB_TC;
    assign tmr_en      = (state_q != ST_IDLE);
    // The count runs unbroken across ISSUE and WAIT_RDY so it also measures the timeout.
    assign tmr_clr     = (state_q == ST_IDLE) || (in_op && (state_d == ST_GAP));

    ip_ctrl_timer #(.W(TW)) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (tmr_clr),
        .i_en     (tmr_en),
        .i_tc_val (tmr_tc_val),
        .o_cnt    (tmr_cnt),
        .o_tc     (tmr_tc)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cfg_ack_d    = 1'b0;
        send_ack_d   = 1'b0;
        cfg_done_d   = 1'b0;
        send_done_d  = 1'b0;
        err_d        = 1'b0;
        trig_d       = trig_q;
        set_local_d  = set_local_q;
        set_dest_d   = set_dest_q;
        len_d        = len_q;
        ip_d         = ip_q;
        // Config wins a tie unless it won last time, so a send waits behind at most one config.
        grant_cfg    = bus.i_cfg_req && (!bus.i_send_req || (last_grant_q == GRANT_SEND));

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_cfg_req || bus.i_send_req) begin
                    state_d = ST_ISSUE;
                    if (grant_cfg) begin
                        cfg_ack_d    = 1'b1;
                        ip_d         = bus.i_cfg_ip;
                        set_local_d  = (bus.i_cfg_dst == CFG_LOCAL);
                        set_dest_d   = (bus.i_cfg_dst == CFG_DEST);
                        last_grant_d = GRANT_CFG;
                    end else begin
                        send_ack_d   = 1'b1;
                        len_d        = bus.i_send_len;
                        trig_d       = 1'b1;
                        last_grant_d = GRANT_SEND;
                    end
                end
            end
            ST_ISSUE, ST_WAIT_RDY: begin
                if (bus.i_ip_ready) begin
                    state_d     = ST_GAP;
                    cfg_done_d  = (last_grant_q == GRANT_CFG);
                    send_done_d = (last_grant_q == GRANT_SEND);
                end else if (timeout_hit) begin
                    state_d = ST_GAP;
                    err_d   = 1'b1;
                end else if ((state_q == ST_ISSUE) && tmr_tc) begin
                    state_d = ST_WAIT_RDY;
                end
                if (state_d != ST_ISSUE) begin
                    trig_d      = 1'b0;
                    set_local_d = 1'b0;
                    set_dest_d  = 1'b0;
                end
            end
            ST_GAP: begin
                if (tmr_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_SEND;
            cfg_ack_q    <= 1'b0;
            send_ack_q   <= 1'b0;
            cfg_done_q   <= 1'b0;
            send_done_q  <= 1'b0;
            err_q        <= 1'b0;
            trig_q       <= 1'b0;
            set_local_q  <= 1'b0;
            set_dest_q   <= 1'b0;
            len_q        <= '0;
            ip_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cfg_ack_q    <= cfg_ack_d;
            send_ack_q   <= send_ack_d;
            cfg_done_q   <= cfg_done_d;
            send_done_q  <= send_done_d;
            err_q        <= err_d;
            trig_q       <= trig_d;
            set_local_q  <= set_local_d;
            set_dest_q   <= set_dest_d;
            len_q        <= len_d;
            ip_q         <= ip_d;
        end
    end

    assign bus.o_cfg_ack        = cfg_ack_q;
    assign bus.o_send_ack       = send_ack_q;
    assign bus.o_cfg_done       = cfg_done_q;
    assign bus.o_send_done      = send_done_q;
    assign bus.o_err            = err_q;
    assign bus.o_ip_trig        = trig_q;
    assign bus.o_ip_set_local   = set_local_q;
    assign bus.o_ip_set_dest    = set_dest_q;
    assign bus.o_ip_data_length = len_q;
    assign bus.o_ip0            = ip_q[31:24];
    assign bus.o_ip1            = ip_q[23:16];
    assign bus.o_ip2            = ip_q[15:8];
    assign bus.o_ip3            = ip_q[7:0];
    assign bus.o_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ip_hdr_ctrl.sv
// Bench for ip_hdr_ctrl: behavioural header generator, completion scoreboard and directed scenarios.
module tb_ip_hdr_ctrl;
    import ip_ctrl_pkg::*;

    localparam int STB     = 2;
    localparam int GAP     = 2;
    localparam int TO      = 64;
    localparam int GEN_LAT = 3;

    localparam logic [2:0] K_SEND = 3'b001;
    localparam logic [2:0] K_CFG  = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ip_hdr_ctrl_if bus();

    ip_hdr_ctrl #(.STROBE_CYC(STB), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0]  kind;
        logic [15:0] len;
        logic [31:0] ip;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] m_len = '0;
    logic [31:0] m_ip  = '0;
    logic [31:0] ip_out;
    assign ip_out = {bus.o_ip0, bus.o_ip1, bus.o_ip2, bus.o_ip3};

    // Generator model: latches on strobe rising edges, ready GEN_LAT cycles later unless muted.
    logic        gen_rdy, gen_mute, spur_rdy;
    logic        g_trig_p, g_loc_p, g_dst_p, g_busy;
    logic [3:0]  g_cnt;
    logic [31:0] g_src, g_dst;
    logic [15:0] g_tot;
    logic [7:0]  hdr [0:19];
    assign bus.i_ip_ready = gen_rdy | spur_rdy;

    always @(posedge clk) begin
        if (rst) begin
            gen_rdy  <= 1'b0;
            g_trig_p <= 1'b0;
            g_loc_p  <= 1'b0;
            g_dst_p  <= 1'b0;
            g_busy   <= 1'b0;
            g_cnt    <= '0;
        end else begin
            gen_rdy  <= 1'b0;
            g_trig_p <= bus.o_ip_trig;
            g_loc_p  <= bus.o_ip_set_local;
            g_dst_p  <= bus.o_ip_set_dest;
            if ((bus.o_ip_trig && !g_trig_p) || (bus.o_ip_set_local && !g_loc_p) ||
                (bus.o_ip_set_dest && !g_dst_p)) begin
                g_busy <= 1'b1;
                g_cnt  <= 4'(GEN_LAT);
                if (bus.o_ip_set_local) g_src <= ip_out;
                if (bus.o_ip_set_dest)  g_dst <= ip_out;
                if (bus.o_ip_trig) begin
                    g_tot = bus.o_ip_data_length + 16'd20;
                    hdr[2]  <= g_tot[15:8];
                    hdr[3]  <= g_tot[7:0];
                    hdr[16] <= g_dst[31:24];
                    hdr[17] <= g_dst[23:16];
                    hdr[18] <= g_dst[15:8];
                    hdr[19] <= g_dst[7:0];
                end
            end else if (g_busy) begin
                if (g_cnt == 4'd1) begin
                    g_busy <= 1'b0;
                    if (!gen_mute) gen_rdy <= 1'b1;
                end else begin
                    g_cnt <= g_cnt - 4'd1;
                end
            end
        end
    end

    int  w_trig = 0, w_loc = 0, w_dst = 0;
    sb_t e_pop;
    always @(negedge clk) begin
        if (bus.o_ip_trig) w_trig++;
        else if (w_trig != 0) begin chk("trig_width", 64'(w_trig), 64'(STB)); w_trig = 0; end
        if (bus.o_ip_set_local) w_loc++;
        else if (w_loc != 0) begin chk("loc_width", 64'(w_loc), 64'(STB)); w_loc = 0; end
        if (bus.o_ip_set_dest) w_dst++;
        else if (w_dst != 0) begin chk("dst_width", 64'(w_dst), 64'(STB)); w_dst = 0; end
        if (bus.o_cfg_ack || bus.o_send_ack)
            chk("ack_excl", 64'(bus.o_cfg_ack & bus.o_send_ack), 64'd0);
        if (bus.o_send_done || bus.o_cfg_done || bus.o_err) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 64'({bus.o_err, bus.o_cfg_done, bus.o_send_done}), 64'd0);
            end else begin
                e_pop = sb_q.pop_front();
                chk("sb_kind", 64'({bus.o_err, bus.o_cfg_done, bus.o_send_done}), 64'(e_pop.kind));
                chk("sb_len", 64'(bus.o_ip_data_length), 64'(e_pop.len));
                chk("sb_ip", 64'(ip_out), 64'(e_pop.ip));
            end
        end
    end

    task automatic push_exp(input logic [2:0] kind);
        sb_t e;
        e.kind = kind;
        e.len  = m_len;
        e.ip   = m_ip;
        sb_q.push_back(e);
    endtask

    task automatic wait_evt(output longint t);
        bit seen = 1'b0;
        t = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_send_done || bus.o_cfg_done || bus.o_err) begin
                seen = 1'b1;
                t = longint'($time);
            end
        end
        if (!seen) chk("evt_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clk);
            idle = !bus.o_busy;
        end
        if (!idle) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {bus.o_cfg_ack, bus.o_send_ack, bus.o_cfg_done, bus.o_send_done, bus.o_err,
                  bus.o_ip_trig, bus.o_ip_set_local, bus.o_ip_set_dest, bus.o_busy,
                  bus.o_ip_data_length, ip_out}, 64'd0);
    endtask

    // Called at a negedge with the DUT idle; returns once it is idle again.
    task automatic run_op(input bit is_cfg, input bit dst, input logic [31:0] ip,
                          input logic [15:0] len, input bit exp_err, input bit spur_gap);
        longint t_ack, t_evt;
        if (is_cfg) m_ip = ip; else m_len = len;
        push_exp(exp_err ? K_ERR : (is_cfg ? K_CFG : K_SEND));
        if (is_cfg) begin
            bus.i_cfg_dst = dst; bus.i_cfg_ip = ip; bus.i_cfg_req = 1'b1;
        end else begin
            bus.i_send_len = len; bus.i_send_req = 1'b1;
        end
        @(negedge clk);
        t_ack = longint'($time);
        chk("ack_latency", 64'(is_cfg ? bus.o_cfg_ack : bus.o_send_ack), 64'd1);
        chk("strobe_sel", 64'({bus.o_ip_trig, bus.o_ip_set_local, bus.o_ip_set_dest}),
            64'(is_cfg ? (dst ? 3'b001 : 3'b010) : 3'b100));
        bus.i_cfg_req  = 1'b0;
        bus.i_send_req = 1'b0;
        wait_evt(t_evt);
        if (exp_err) chk("timeout_latency", 64'((t_evt - t_ack) / 10), 64'(TO));
        for (int g = 0; g < GAP; g++) begin
            chk("gap_busy", 64'(bus.o_busy), 64'd1);
            spur_rdy = spur_gap && (g == 0);
            @(negedge clk);
            spur_rdy = 1'b0;
        end
        chk("busy_fall", 64'(bus.o_busy), 64'd0);
    endtask

    initial begin
        int  n_grant;
        bit  rc_c, rc_s;
        longint t_dummy;

        bus.i_cfg_req  = 1'b0;
        bus.i_cfg_dst  = 1'b0;
        bus.i_cfg_ip   = '0;
        bus.i_send_req = 1'b0;
        bus.i_send_len = '0;
        gen_mute = 1'b0;
        spur_rdy = 1'b0;

        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 64'(bus.o_busy), 64'd0);

        run_op(1'b0, 1'b0, '0, 16'd100, 1'b0, 1'b0);
        chk("hdr2_len100", 64'(hdr[2]), 64'h00);
        chk("hdr3_len100", 64'(hdr[3]), 64'h78);

        run_op(1'b1, CFG_DEST, 32'hC0A8010A, '0, 1'b0, 1'b0);
        run_op(1'b0, 1'b0, '0, 16'd200, 1'b0, 1'b1);
        chk("hdr3_len200", 64'(hdr[3]), 64'hDC);
        chk("hdr_dst", 64'({hdr[16], hdr[17], hdr[18], hdr[19]}), 64'hC0A8010A);

        spur_rdy = 1'b1;
        @(negedge clk);
        spur_rdy = 1'b0;
        chk("spur_idle_busy", 64'(bus.o_busy), 64'd0);
        @(negedge clk);
        chk("spur_idle_busy2", 64'(bus.o_busy), 64'd0);

        // Both requesters always pending: grants must alternate starting with config.
        m_ip = 32'h0A000001; push_exp(K_CFG);
        m_len = 16'd300;     push_exp(K_SEND);
        push_exp(K_CFG);
        push_exp(K_SEND);
        bus.i_cfg_dst = CFG_LOCAL; bus.i_cfg_ip = 32'h0A000001; bus.i_send_len = 16'd300;
        bus.i_cfg_req = 1'b1; bus.i_send_req = 1'b1;
        n_grant = 0; rc_c = 1'b0; rc_s = 1'b0;
        for (int c = 0; c < 2000 && n_grant < 4; c++) begin
            @(negedge clk);
            if (rc_c) begin bus.i_cfg_req = 1'b1; rc_c = 1'b0; end
            if (rc_s) begin bus.i_send_req = 1'b1; rc_s = 1'b0; end
            if (bus.o_cfg_ack || bus.o_send_ack) begin
                chk("arb_order", 64'(bus.o_cfg_ack), 64'(n_grant % 2 == 0));
                n_grant++;
                if (bus.o_cfg_ack)  begin bus.i_cfg_req = 1'b0;  rc_c = (n_grant < 4); end
                if (bus.o_send_ack) begin bus.i_send_req = 1'b0; rc_s = (n_grant < 4); end
            end
        end
        chk("arb_grants", 64'(n_grant), 64'd4);
        bus.i_cfg_req = 1'b0; bus.i_send_req = 1'b0;
        wait_idle();

        gen_mute = 1'b1;
        run_op(1'b0, 1'b0, '0, 16'd50, 1'b1, 1'b0);
        gen_mute = 1'b0;
        run_op(1'b0, 1'b0, '0, 16'd60, 1'b0, 1'b0);
        chk("hdr3_len60", 64'(hdr[3]), 64'h50);

        // Reset while waiting for ready, with a config request pending.
        gen_mute = 1'b1;
        bus.i_send_len = 16'd77; bus.i_send_req = 1'b1;
        @(negedge clk);
        chk("rst_case_ack", 64'(bus.o_send_ack), 64'd1);
        bus.i_send_req = 1'b0;
        repeat (4) @(negedge clk);
        bus.i_cfg_dst = CFG_LOCAL; bus.i_cfg_ip = 32'h01020304; bus.i_cfg_req = 1'b1;
        @(negedge clk);
        chk("busy_no_ack", 64'({bus.o_busy, bus.o_cfg_ack}), 64'b10);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("reset_mid_op");
        rst = 1'b0;
        gen_mute = 1'b0;
        m_len = '0; m_ip = 32'h01020304;
        push_exp(K_CFG);
        @(negedge clk);
        chk("reack_after_reset", 64'(bus.o_cfg_ack), 64'd1);
        bus.i_cfg_req = 1'b0;
        wait_evt(t_dummy);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
